imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer in front of instruction_mem. Holds the PC and drives instruction_mem's read address (combinational read, same-cycle data). Buffers fetched words in a small FIFO toward decode with a valid/ready handshake. Handles redirects from branch/jump resolution and halts on misaligned or out-of-range fetch addresses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
IMEM_BYTES, 1024, byte size of instruction_mem; fetch at address >= IMEM_BYTES faults
FIFO_DEPTH, 2, fetch buffer entries (power of 2, >= 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  fetch enable; 0 pauses fetching (buffer still drains)
imem_addr  out  32  read address to instruction_mem (equals PC)
imem_instr  in  32  instruction word returned combinationally
redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  32  new fetch target
if_valid  out  1  buffer head valid toward decode
if_ready  in  1  decode accepts head this cycle
if_instr  out  32  head instruction
if_pc  out  32  head PC
fault  out  1  sticky fetch fault
fault_cause  out  2  00 none, 01 misaligned, 10 out-of-range
fault_pc  out  32  PC that faulted

Behaviour:
- Reset (async, rst=1): PC=RESET_PC, FIFO empty, state IDLE, if_valid=0, if_instr=0, if_pc=0, fault=0, fault_cause=00, fault_pc=0. imem_addr=PC at all times.
- States: IDLE, FETCH, FAULT.
- IDLE -> FETCH when en=1 (first push no earlier than the cycle after). FETCH -> IDLE when en=0; buffered entries remain poppable.
- FETCH push rule: each cycle with no redirect, en=1, PC aligned and < IMEM_BYTES, and (count<FIFO_DEPTH or pop this cycle): push {PC, imem_instr}, PC<=PC+4 (32-bit wrap). Throughput 1 instr/cycle; latency PC->if_valid = 1 cycle.
- Pop: if_valid && if_ready. Push and pop in the same cycle: count unchanged. Full without pop: no push, PC holds.
- Fault check in FETCH: PC[1:0]!=0 -> cause 01; else PC>=IMEM_BYTES -> cause 10. Misaligned takes priority. Go to FAULT: fault=1, fault_cause/fault_pc latched, no push, PC holds. Entries pushed earlier still drain.
- FAULT exits only on redirect or reset.
- Redirect (any state, highest priority): FIFO flushed (if_valid=0 next cycle), PC<=redirect_pc, fault/fault_cause cleared. Next state: FETCH if en=1, else IDLE. A pop or push in the redirect cycle is discarded. A misaligned redirect_pc faults on the following cycle.
- if_instr/if_pc present the FIFO head; they hold their value while if_valid=0.
- Reset mid-operation: immediate return to reset values, no partial entries.

Optional Feature:
FETCH_PERF_EN: adds outputs perf_fetched[31:0] (pushes) and perf_stall[31:0] (FETCH cycles with FIFO full and no pop). Both wrap, clear on reset, and are not cleared by redirect. Without the macro these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package imem_pkg: fetch_state_t enum (IDLE, FETCH, FAULT), fault_cause_t enum (NONE=2'b00, MISALIGN=2'b01, OOR=2'b10), INSTR_W=32, NOP_INSTR=32'h0000_0013.
- Sub-module fetch_fifo: parameterised synchronous FIFO (push, pop, flush, full, empty, count, 64-bit {pc, instr} data), instantiated once.

Test Plan:
- Reset, en=1, if_ready=1, memory words 0..7 preloaded -> if_pc 0,4,...,28 on consecutive cycles, if_instr matches memory, first if_valid one cycle after FETCH entry.
- if_ready=0 for 5 cycles -> exactly 2 entries buffered (PC 0, 4), imem_addr held at 8, perf_stall=3 when FETCH_PERF_EN is defined. Release -> 0, 4, 8 in order, nothing lost or duplicated.
- redirect_valid with redirect_pc=0x10 while FIFO is full -> next cycle if_valid=0, then if_pc=0x10, 0x14.
- redirect_pc=0x2 -> fault=1, fault_cause=01, fault_pc=0x2, no further pushes; a later redirect to 0x0 clears fault and resumes.
- PC reaches 1020 with IMEM_BYTES=1024 -> PC 1020 delivered, then fault_cause=10, fault_pc=1024.
- Assert rst while FIFO holds 2 entries and fault=1 -> all outputs return to reset values asynchronously; fetch restarts at RESET_PC after rst falls.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-fetch sequencer
package imem_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    FAULT = 2'b10
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    MISALIGN = 2'b01,
    OOR      = 2'b10
  } fault_cause_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous {pc, instr} buffer between fetch and decode, with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  // Flush wins over both ports; a push into a full buffer is only legal alongside a pop.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: an empty buffer never exposes its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch sequencer: PC, imem address, decode buffer, fault halt (FETCH_PERF_EN adds counters)
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic               fault,
  output logic [1:0]         fault_cause,
  output logic [31:0]        fault_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  fetch_state_t state_q, state_d;
  fault_cause_t cause_q, cause_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [2*INSTR_W-1:0] hold_q;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [2*INSTR_W-1:0] fifo_rdata;

  assign fifo_pop = !fifo_empty && if_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2*INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata ({pc_q, imem_instr}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assert property (@(posedge clk) disable iff (rst) fifo_empty == (fifo_count == '0));

  assign imem_addr   = pc_q;
  assign if_valid    = !fifo_empty;
  // While the buffer is empty decode sees the last head it was shown.
  assign {if_pc, if_instr} = fifo_empty ? hold_q : fifo_rdata;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign fault_pc    = fault_pc_q;

  // Next-state: redirect overrides everything; FETCH faults before it pushes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    fault_pc_d = fault_pc_q;
    fifo_push  = 1'b0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      fault_d = 1'b0;
      cause_d = NONE;
      state_d = en ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) state_d = FETCH;
        end
        FETCH: begin
          if (!en) begin
            state_d = IDLE;
          end else if (pc_q[1:0] != 2'b00) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            cause_d    = MISALIGN;
            fault_pc_d = pc_q;
          end else if (pc_q >= IMEM_LIMIT) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            cause_d    = OOR;
            fault_pc_d = pc_q;
          end else if (!fifo_full || fifo_pop) begin
            fifo_push = 1'b1;
            pc_d      = pc_q + 32'd4;
          end
        end
        FAULT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC and fault registers; hold_q tracks the head shown to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      cause_q    <= NONE;
      fault_pc_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      fault_pc_q <= fault_pc_d;
      if (!fifo_empty) hold_q <= fifo_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Pushes and FETCH cycles blocked by a full buffer; redirects leave both running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (fifo_push) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (state_q == FETCH && fifo_full && !fifo_pop) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl against a queue-based fetch model
module tb_imem_fetch_ctrl;

  localparam int DEPTH      = 2;
  localparam int IMEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] mem [256];
  assign imem_instr = mem[imem_addr[9:2]];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0),
    .IMEM_BYTES (IMEM_BYTES),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .fault_pc       (fault_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue of fetched {pc, instr} words plus a run mode (0 idle, 1 running, 2 halted).
  logic [63:0] mq [$];
  logic [63:0] m_hold;
  logic [31:0] m_pc, m_fpc, m_fetched, m_stall;
  logic [1:0]  m_cause;
  int          m_mode;

  function automatic void model_reset();
    mq.delete();
    m_hold = '0; m_pc = '0; m_fpc = '0; m_fetched = '0; m_stall = '0;
    m_cause = 2'b00; m_mode = 0;
  endfunction

  function automatic logic [63:0] model_head();
    return (mq.size() != 0) ? mq[0] : m_hold;
  endfunction

  function automatic void model_edge();
    bit pop;
    pop = (mq.size() != 0) && if_ready;
    if (mq.size() != 0) m_hold = mq[0];
    if (m_mode == 1 && mq.size() == DEPTH && !pop) m_stall = m_stall + 1;
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc;
      m_cause = 2'b00;
      m_mode = en ? 1 : 0;
      return;
    end
    if (pop) void'(mq.pop_front());
    if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!en) m_mode = 0;
      else if ((m_pc % 4) != 0) begin m_mode = 2; m_cause = 2'b01; m_fpc = m_pc; end
      else if (m_pc >= IMEM_BYTES) begin m_mode = 2; m_cause = 2'b10; m_fpc = m_pc; end
      else if (mq.size() < DEPTH) begin
        mq.push_back({m_pc, mem[m_pc[9:2]]});
        m_pc = m_pc + 32'd4;
        m_fetched = m_fetched + 1;
      end
    end
  endfunction

  task automatic step(input bit e, input bit rdy, input bit rv, input logic [31:0] rpc);
    en = e; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    en = 0; if_ready = 0; redirect_valid = 0; redirect_pc = '0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    en = 0; if_ready = 0; redirect_valid = 0; redirect_pc = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
    vectors++; if (if_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    vectors++; if ({fault, fault_cause} !== 3'b000) begin miscompares++; $display("FAIL reset_fault got=%b/%b exp=0/00", fault, fault_cause); end
    vectors++; if (fault_pc !== 32'h0) begin miscompares++; $display("FAIL reset_fault_pc got=%h exp=0", fault_pc); end
    rst = 0;
  endtask

  task automatic test_stream();
    step(1, 1, 0, '0);
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL stream_first got=%b exp=0", if_valid); end
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 0, '0);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'(4*k) || if_instr !== mem[k])
        begin miscompares++; $display("FAIL stream_word k=%0d got=%b/%h/%h exp=1/%h/%h", k, if_valid, if_pc, if_instr, 4*k, mem[k]); end
      vectors++; if (imem_addr !== 32'(4*k+4)) begin miscompares++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, 4*k+4); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1, 1, 0, '0);
    repeat (5) step(1, 0, 0, '0);
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem[0])
      begin miscompares++; $display("FAIL bp_head got=%b/%h/%h exp=1/0/%h", if_valid, if_pc, if_instr, mem[0]); end
    vectors++; if (imem_addr !== 32'h8) begin miscompares++; $display("FAIL bp_addr got=%h exp=8", imem_addr); end
`ifdef FETCH_PERF_EN
    vectors++; if (perf_stall !== 32'd3 || perf_fetched !== 32'd2)
      begin miscompares++; $display("FAIL bp_perf got=%0d/%0d exp=2/3", perf_fetched, perf_stall); end
`endif
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 0, '0);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'(4*k) || if_instr !== mem[k])
        begin miscompares++; $display("FAIL bp_release k=%0d got=%b/%h exp=1/%h", k, if_valid, if_pc, 4*k); end
    end
  endtask

  task automatic test_redirect_full();
    repeat (2) step(1, 0, 0, '0);
    vectors++; if (if_valid !== 1'b1) begin miscompares++; $display("FAIL rdf_prefill got=%b exp=1", if_valid); end
    step(1, 1, 1, 32'h10);
    vectors++; if (if_valid !== 1'b0 || imem_addr !== 32'h10)
      begin miscompares++; $display("FAIL rdf_flush got=%b/%h exp=0/10", if_valid, imem_addr); end
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 0, '0);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'(16+4*k) || if_instr !== mem[4+k])
        begin miscompares++; $display("FAIL rdf_resume got=%b/%h exp=1/%h", if_valid, if_pc, 16+4*k); end
    end
  endtask

  task automatic test_misalign();
    step(1, 1, 1, 32'h2);
    vectors++; if (if_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h2)
      begin miscompares++; $display("FAIL mis_redirect got=%b/%b/%h exp=0/0/2", if_valid, fault, imem_addr); end
    step(1, 1, 0, '0);
    vectors++; if (fault !== 1'b1 || fault_cause !== 2'b01 || fault_pc !== 32'h2)
      begin miscompares++; $display("FAIL mis_fault got=%b/%b/%h exp=1/01/2", fault, fault_cause, fault_pc); end
    repeat (3) begin
      step(1, 1, 0, '0);
      vectors++; if (if_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 32'h2)
        begin miscompares++; $display("FAIL mis_halt got=%b/%b/%h exp=0/1/2", if_valid, fault, imem_addr); end
    end
    step(1, 1, 1, 32'h0);
    vectors++; if (fault !== 1'b0 || fault_cause !== 2'b00)
      begin miscompares++; $display("FAIL mis_clear got=%b/%b exp=0/00", fault, fault_cause); end
    step(1, 1, 0, '0);
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0)
      begin miscompares++; $display("FAIL mis_resume got=%b/%h exp=1/0", if_valid, if_pc); end
  endtask

  task automatic test_oor();
    step(1, 1, 1, 32'd1012);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, '0);
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'(1012+4*k) || if_instr !== mem[253+k])
        begin miscompares++; $display("FAIL oor_word got=%b/%h exp=1/%0d", if_valid, if_pc, 1012+4*k); end
    end
    step(1, 1, 0, '0);
    vectors++; if (fault !== 1'b1 || fault_cause !== 2'b10 || fault_pc !== 32'd1024)
      begin miscompares++; $display("FAIL oor_fault got=%b/%b/%h exp=1/10/400", fault, fault_cause, fault_pc); end
    vectors++; if (if_valid !== 1'b0 || if_pc !== 32'd1020 || if_instr !== mem[255])
      begin miscompares++; $display("FAIL oor_hold got=%b/%h/%h exp=0/3fc/%h", if_valid, if_pc, if_instr, mem[255]); end
  endtask

  task automatic test_async_reset();
    step(1, 0, 1, 32'd1016);
    repeat (3) step(1, 0, 0, '0);
    vectors++; if (fault !== 1'b1 || if_valid !== 1'b1 || if_pc !== 32'd1016)
      begin miscompares++; $display("FAIL ar_setup got=%b/%b/%h exp=1/1/3f8", fault, if_valid, if_pc); end
    #2 rst = 1;
    #1;
    vectors++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_addr !== 32'h0)
      begin miscompares++; $display("FAIL ar_outputs got=%b/%h/%h/%h exp=0/0/0/0", if_valid, if_pc, if_instr, imem_addr); end
    vectors++; if (fault !== 1'b0 || fault_cause !== 2'b00 || fault_pc !== 32'h0)
      begin miscompares++; $display("FAIL ar_fault got=%b/%b/%h exp=0/00/0", fault, fault_cause, fault_pc); end
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    step(1, 1, 0, '0);
    step(1, 1, 0, '0);
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem[0])
      begin miscompares++; $display("FAIL ar_restart got=%b/%h exp=1/0", if_valid, if_pc); end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    logic [63:0] head;
    bit e, rdy, rv;
    int sel;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      e   = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 39) == 0);
      rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      sel = $urandom_range(0, 7);
      if (sel == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      else if (sel == 1) rpc = 32'd1012 + 32'($urandom_range(0, 3)) * 32'd4;
      step(e, rdy, rv, rpc);
      head = model_head();
      vectors++; if (if_valid !== (mq.size() != 0) || {if_pc, if_instr} !== head)
        begin miscompares++; $display("FAIL rnd_head cyc=%0d got=%b/%h/%h exp=%b/%h/%h", c, if_valid, if_pc, if_instr, mq.size() != 0, head[63:32], head[31:0]); end
      vectors++; if (imem_addr !== m_pc) begin miscompares++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, imem_addr, m_pc); end
      vectors++; if (fault !== (m_cause != 2'b00) || fault_cause !== m_cause)
        begin miscompares++; $display("FAIL rnd_fault cyc=%0d got=%b/%b exp=%b/%b", c, fault, fault_cause, m_cause != 2'b00, m_cause); end
      if (m_cause != 2'b00) begin
        vectors++; if (fault_pc !== m_fpc) begin miscompares++; $display("FAIL rnd_fault_pc cyc=%0d got=%h exp=%h", c, fault_pc, m_fpc); end
      end
`ifdef FETCH_PERF_EN
      vectors++; if (perf_fetched !== m_fetched || perf_stall !== m_stall)
        begin miscompares++; $display("FAIL rnd_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", c, perf_fetched, perf_stall, m_fetched, m_stall); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misalign();
    test_oor();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
